// File: rtl/axi4_rd_credit_pkg.sv
// Shared types and helpers for the AXI4-Lite read credit buffer.
// Response codes, R entry layout and level width helper.
package axi4_rd_credit_pkg;

  localparam int N_DEF = 4;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef struct packed {
    logic [1:0]           resp;
    logic [8*N_DEF-1:0]   data;
  } r_entry_t;

  function automatic int lvl_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_level.sv
// First-word fall-through FIFO with occupancy output.
// Pointers carry one extra bit to tell full from empty.
module sync_fifo_level
  import axi4_rd_credit_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [W-1:0]          wr_data,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [W-1:0]          rd_data,
  output logic                  rd_empty,
  output logic [lvl_w(D)-1:0]   level
);

  localparam int AW = $clog2(D);
  localparam int LW = lvl_w(D);

  logic [W-1:0] mem_q [D];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         do_wr, do_rd;

  assign level    = LW'(wptr_q - rptr_q);
  assign wr_full  = (level == LW'(D));
  assign rd_empty = (level == '0);
  assign do_wr    = wr_en & ~wr_full;
  assign do_rd    = rd_en & ~rd_empty;
  assign rd_data  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axi4_lite_rd_credit_fifos.sv
// AXI4-Lite read buffer: AR and R FIFOs with credit admission.
// An AR is taken only when an R slot is reserved for its answer.
module axi4_lite_rd_credit_fifos
  import axi4_rd_credit_pkg::*;
#(
  parameter int A    = 32,
  parameter int N    = 4,
  parameter int AR_D = 4,
  parameter int R_D  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [A-1:0]             araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [8*N-1:0]           rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [A-1:0]             be_ar_addr,
  output logic                     be_ar_valid,
  input  logic                     be_ar_ready,
  input  logic [8*N-1:0]           be_r_data,
  input  logic [1:0]               be_r_resp,
  input  logic                     be_r_valid,
  output logic                     be_r_ready,
  output logic [lvl_w(R_D)-1:0]    outstanding,
  output logic [lvl_w(AR_D)-1:0]   ar_level,
  output logic [lvl_w(R_D)-1:0]    r_level,
  output logic                     err_unsol,
  input  logic                     err_clr
);

  localparam int OW = lvl_w(R_D);
  localparam logic [OW-1:0] OUT_MAX = OW'(R_D);

  typedef struct packed {
    logic [1:0]     resp;
    logic [8*N-1:0] data;
  } r_ent_t;

  logic          ar_push, ar_pop;
  logic          ar_full, ar_empty;
  logic          r_push, r_pop;
  logic          r_full, r_empty;
  logic          rsp_hs, unsol;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] pending;
  logic          err_q, err_d;
  r_ent_t        r_wr, r_rd;

  // Credit check uses only registered state, so no path from be_ar_ready.
  assign arready     = ~reset & ~ar_full & (out_q < OUT_MAX);
  assign ar_push     = arvalid & arready;
  assign be_ar_valid = ~reset & ~ar_empty;
  assign ar_pop      = be_ar_valid & be_ar_ready;

  sync_fifo_level #(
    .W (A),
    .D (AR_D)
  ) u_ar_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (ar_push),
    .wr_data  (araddr),
    .wr_full  (ar_full),
    .rd_en    (ar_pop),
    .rd_data  (be_ar_addr),
    .rd_empty (ar_empty),
    .level    (ar_level)
  );

  assign be_r_ready = reset | ~r_full;
  assign pending    = out_q - OW'(ar_level) - r_level;
  assign rsp_hs     = ~reset & be_r_valid & be_r_ready;
  assign r_push     = rsp_hs & (pending != '0);
  assign unsol      = rsp_hs & (pending == '0);
  assign r_wr       = '{resp: be_r_resp, data: be_r_data};

  sync_fifo_level #(
    .W ($bits(r_ent_t)),
    .D (R_D)
  ) u_r_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (r_push),
    .wr_data  (r_wr),
    .wr_full  (r_full),
    .rd_en    (r_pop),
    .rd_data  (r_rd),
    .rd_empty (r_empty),
    .level    (r_level)
  );

  assign rvalid = ~reset & ~r_empty;
  assign r_pop  = rvalid & rready;
  assign rdata  = r_rd.data;
  assign rresp  = r_rd.resp;

  always_comb begin
    out_d = out_q;
    unique case (1'b1)
      (ar_push & ~r_pop): out_d = out_q + 1'b1;
      (r_pop & ~ar_push): out_d = out_q - 1'b1;
      default:            out_d = out_q;
    endcase
  end

  // A new unsolicited response wins over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (unsol)        err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign outstanding = out_q;
  assign err_unsol   = err_q;

endmodule

// File: tb/tb_axi4_lite_rd_credit_fifos.sv
// Bench for axi4_lite_rd_credit_fifos: vector table, corner
// sequences and randomized traffic against a queue model.
module tb_axi4_lite_rd_credit_fifos;
  import axi4_rd_credit_pkg::*;

  localparam int R_D  = 4;
  localparam int AR_D = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] be_ar_addr;
  logic        be_ar_valid;
  logic        be_ar_ready = 1'b0;
  logic [31:0] be_r_data = '0;
  logic [1:0]  be_r_resp = '0;
  logic        be_r_valid = 1'b0;
  logic        be_r_ready;
  logic [2:0]  outstanding;
  logic [2:0]  ar_level;
  logic [2:0]  r_level;
  logic        err_unsol;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  axi4_lite_rd_credit_fifos #(
    .A(32), .N(4), .AR_D(AR_D), .R_D(R_D)
  ) dut (
    .clk(clk), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .be_ar_addr(be_ar_addr), .be_ar_valid(be_ar_valid),
    .be_ar_ready(be_ar_ready),
    .be_r_data(be_r_data), .be_r_resp(be_r_resp),
    .be_r_valid(be_r_valid), .be_r_ready(be_r_ready),
    .outstanding(outstanding), .ar_level(ar_level),
    .r_level(r_level), .err_unsol(err_unsol), .err_clr(err_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle();
    arvalid = 1'b0; araddr = '0; be_ar_ready = 1'b0;
    be_r_valid = 1'b0; be_r_data = '0; be_r_resp = '0;
    rready = 1'b0; err_clr = 1'b0;
  endtask

  // Back-end answer for a given request address.
  function automatic logic [33:0] fmod(input logic [31:0] a);
    logic [31:0] d;
    d = (a * 32'h9E3779B1) ^ 32'h0000_1234;
    return {a[3:2], d};
  endfunction

  typedef struct {
    logic        arv;
    logic [31:0] addr;
    logic        bar;
    logic        brv;
    logic [31:0] bd;
    logic [1:0]  brs;
    logic        rr;
    logic        clr;
    logic        e_arr;
    logic        e_bav;
    logic [31:0] e_baa;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [1:0]  e_rs;
    logic [2:0]  e_out;
    logic        e_err;
    logic        e_brr;
  } vec_t;

  vec_t tv [13];

  // Transaction-level model state
  logic [31:0] arq [$];
  logic [31:0] beq [$];
  logic [33:0] rexp [$];
  int oc = 0;
  int rl = 0;

  task automatic run(input int max_cyc, input int p_ar,
                     input int p_o, input int target,
                     output int pops, output int cyc);
    logic ar_hs, bear_hs, ber_hs, r_hs;
    pops = 0;
    for (cyc = 0; cyc < max_cyc && pops < target; cyc++) begin
      step();
      arvalid = ($urandom_range(99) < p_ar);
      araddr = $urandom();
      be_ar_ready = ($urandom_range(99) < p_o);
      rready = ($urandom_range(99) < p_o);
      err_clr = 1'b0;
      if (beq.size() > 0) begin
        be_r_valid = ($urandom_range(99) < p_o);
        {be_r_resp, be_r_data} = fmod(beq[0]);
      end else begin
        be_r_valid = 1'b0;
        be_r_data = '0;
        be_r_resp = '0;
      end
      samp();
      chk("rnd_out", 64'(outstanding), 64'(oc));
      chk("rnd_arlvl", 64'(ar_level), 64'(arq.size()));
      chk("rnd_rlvl", 64'(r_level), 64'(rl));
      chk("rnd_arready", 64'(arready),
          64'(oc < R_D && arq.size() < AR_D));
      chk("rnd_brready", 64'(be_r_ready), 64'(rl < R_D));
      chk("rnd_rvalid", 64'(rvalid), 64'(rl > 0));
      chk("rnd_err", 64'(err_unsol), 64'(0));
      ar_hs = arvalid & arready;
      bear_hs = be_ar_valid & be_ar_ready;
      ber_hs = be_r_valid & be_r_ready;
      r_hs = rvalid & rready;
      if (bear_hs) begin
        if (arq.size() > 0) begin
          chk("rnd_be_addr", 64'(be_ar_addr), 64'(arq[0]));
          beq.push_back(arq.pop_front());
        end else begin
          chk("rnd_be_spurious", 64'(1), 64'(0));
        end
      end
      if (r_hs) begin
        if (rexp.size() > 0) begin
          chk("rnd_rdata", 64'({rresp, rdata}), 64'(rexp[0]));
          void'(rexp.pop_front());
        end else begin
          chk("rnd_r_spurious", 64'(1), 64'(0));
        end
        oc--; rl--; pops++;
      end
      if (ber_hs) begin
        void'(beq.pop_front());
        rl++;
      end
      if (ar_hs) begin
        arq.push_back(araddr);
        rexp.push_back(fmod(araddr));
        oc++;
      end
    end
  endtask

  initial begin
    int acc, k, pops, cyc;

    tv[0]  = '{H, 32'h1000, L, L, 32'h0, 2'd0, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, L, H};
    tv[1]  = '{L, 32'h0, H, L, 32'h0, 2'd0, L, L,
               H, H, 32'h1000, L, 32'h0, 2'd0, 3'd1, L, H};
    tv[2]  = '{L, 32'h0, L, H, 32'hDEADBEEF, RESP_OKAY, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd1, L, H};
    tv[3]  = '{L, 32'h0, L, L, 32'h0, 2'd0, H, L,
               H, L, 32'h0, H, 32'hDEADBEEF, RESP_OKAY, 3'd1, L, H};
    tv[4]  = '{L, 32'h0, L, L, 32'h0, 2'd0, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, L, H};
    tv[5]  = '{L, 32'h0, L, H, 32'h55, RESP_SLVERR, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, L, H};
    tv[6]  = '{L, 32'h0, L, L, 32'h0, 2'd0, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, H, H};
    tv[7]  = '{L, 32'h0, L, L, 32'h0, 2'd0, L, H,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, H, H};
    tv[8]  = '{L, 32'h0, L, H, 32'h66, 2'd0, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, L, H};
    tv[9]  = '{L, 32'h0, L, H, 32'h77, 2'd0, L, H,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, H, H};
    tv[10] = '{L, 32'h0, L, L, 32'h0, 2'd0, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, H, H};
    tv[11] = '{L, 32'h0, L, L, 32'h0, 2'd0, L, H,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, H, H};
    tv[12] = '{L, 32'h0, L, L, 32'h0, 2'd0, L, L,
               H, L, 32'h0, L, 32'h0, 2'd0, 3'd0, L, H};

    // Reset state
    idle();
    reset = 1'b1;
    step();
    samp();
    chk("rst_arready", 64'(arready), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_bav", 64'(be_ar_valid), 64'(0));
    chk("rst_brready", 64'(be_r_ready), 64'(1));
    step();
    reset = 1'b0;
    samp();
    chk("rel_arready", 64'(arready), 64'(1));
    chk("rel_levels", 64'({outstanding, ar_level, r_level}), 64'(0));
    chk("rel_err", 64'(err_unsol), 64'(0));

    // Single read and error-flag vectors
    for (int i = 0; i < 13; i++) begin
      step();
      arvalid = tv[i].arv; araddr = tv[i].addr;
      be_ar_ready = tv[i].bar; be_r_valid = tv[i].brv;
      be_r_data = tv[i].bd; be_r_resp = tv[i].brs;
      rready = tv[i].rr; err_clr = tv[i].clr;
      samp();
      chk($sformatf("tv%0d_arready", i), 64'(arready), 64'(tv[i].e_arr));
      chk($sformatf("tv%0d_bav", i), 64'(be_ar_valid), 64'(tv[i].e_bav));
      if (tv[i].e_bav)
        chk($sformatf("tv%0d_baa", i), 64'(be_ar_addr), 64'(tv[i].e_baa));
      chk($sformatf("tv%0d_rvalid", i), 64'(rvalid), 64'(tv[i].e_rv));
      if (tv[i].e_rv)
        chk($sformatf("tv%0d_rd", i), 64'({rresp, rdata}),
            64'({tv[i].e_rs, tv[i].e_rd}));
      chk($sformatf("tv%0d_out", i), 64'(outstanding), 64'(tv[i].e_out));
      chk($sformatf("tv%0d_err", i), 64'(err_unsol), 64'(tv[i].e_err));
      chk($sformatf("tv%0d_brr", i), 64'(be_r_ready), 64'(tv[i].e_brr));
    end

    // Credit limit and back-pressure
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      idle();
      arvalid = 1'b1;
      araddr = 32'h2000 + 32'(acc * 4);
      be_ar_ready = 1'b1;
      samp();
      if (arready) acc++;
    end
    step();
    idle();
    samp();
    chk("credit_acc", 64'(acc), 64'(4));
    chk("credit_out", 64'(outstanding), 64'(4));
    chk("credit_arready", 64'(arready), 64'(0));
    k = 0;
    for (int c = 0; c < 10 && k < 4; c++) begin
      step();
      be_r_valid = 1'b1;
      be_r_data = 32'hA0 + 32'(k);
      be_r_resp = 2'(k);
      samp();
      if (be_r_ready) k++;
    end
    step();
    be_r_valid = 1'b0;
    samp();
    chk("bp_count", 64'(k), 64'(4));
    chk("bp_rlvl", 64'(r_level), 64'(4));
    chk("bp_brready", 64'(be_r_ready), 64'(0));
    chk("bp_head", 64'({rvalid, rdata}), 64'({1'b1, 32'hA0}));
    step();
    rready = 1'b1;
    be_r_valid = 1'b1;
    be_r_data = 32'hBAD;
    samp();
    chk("full_pop_brready", 64'(be_r_ready), 64'(0));
    step();
    rready = 1'b0;
    be_r_valid = 1'b0;
    samp();
    chk("credit_back", 64'(arready), 64'(1));
    chk("credit_out3", 64'(outstanding), 64'(3));
    chk("bp_rlvl3", 64'(r_level), 64'(3));
    for (int j = 1; j < 4; j++) begin
      step();
      rready = 1'b1;
      samp();
      chk($sformatf("bp_pop%0d", j), 64'({rvalid, rresp, rdata}),
          64'({1'b1, 2'(j), 32'hA0 + 32'(j)}));
    end
    step();
    idle();
    samp();
    chk("bp_empty", 64'({rvalid, outstanding}), 64'(0));
    chk("bp_err", 64'(err_unsol), 64'(0));

    // Streaming at full rate
    run(1100, 100, 100, 1000, pops, cyc);
    chk("stream_pops", 64'(pops), 64'(1000));
    chk("stream_rate", 64'(cyc <= 1005), 64'(1));
    run(20, 0, 100, 1000000, pops, cyc);
    chk("stream_drain", 64'(oc), 64'(0));

    // Random traffic
    run(3000, 60, 70, 1000000, pops, cyc);
    run(60, 0, 100, 1000000, pops, cyc);
    step();
    idle();
    samp();
    chk("rnd_drained", 64'({outstanding, ar_level, r_level}), 64'(0));

    // Mid-operation reset with reads in flight
    for (int c = 0; c < 3; c++) begin
      step();
      idle();
      arvalid = 1'b1;
      araddr = 32'h3000 + 32'(c * 4);
      be_ar_ready = 1'b1;
      samp();
    end
    step();
    idle();
    be_ar_ready = 1'b1;
    samp();
    step();
    idle();
    be_r_valid = 1'b1;
    be_r_data = 32'h77;
    samp();
    step();
    idle();
    samp();
    chk("mid_out", 64'(outstanding), 64'(3));
    chk("mid_rlvl", 64'(r_level), 64'(1));
    step();
    reset = 1'b1;
    rready = 1'b1;
    samp();
    chk("mid_rst_arready", 64'(arready), 64'(0));
    chk("mid_rst_rvalid", 64'(rvalid), 64'(0));
    chk("mid_rst_bav", 64'(be_ar_valid), 64'(0));
    chk("mid_rst_brready", 64'(be_r_ready), 64'(1));
    step();
    samp();
    step();
    reset = 1'b0;
    samp();
    chk("mid_rel_levels",
        64'({outstanding, ar_level, r_level}), 64'(0));
    chk("mid_rel_arready", 64'(arready), 64'(1));
    for (int c = 0; c < 3; c++) begin
      step();
      samp();
      chk("mid_no_stale", 64'(rvalid), 64'(0));
    end
    step();
    be_r_valid = 1'b1;
    be_r_data = 32'h99;
    samp();
    chk("stale_brready", 64'(be_r_ready), 64'(1));
    step();
    be_r_valid = 1'b0;
    samp();
    chk("stale_unsol", 64'({err_unsol, rvalid}), 64'(2'b10));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
